dmem_responder: RTL and testbench

- Responder for the CPU core's data-memory port; the CPU issues address, write data and write strobe from its MEM stage.
- Provides word-addressed data RAM plus a small MMIO block: GPIO, timer and status.
- Read data is returned combinationally in the same cycle, because the CPU captures it into MEM/WB at the next edge.
- Writes commit at the clock edge.

---
 rtl/dmem_responder_if.sv | 39 +++
 rtl/dmem_responder.sv | 239 +++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------------------------
// dmem_responder_if
//
// Data-memory bus between the CPU MEM stage and the data-memory responder.
// Signal suffixes are from the responder's point of view.
//
//   mem_addr_i     [31:0]  byte address from the CPU (bits [1:0] ignored by the responder)
//   mem_wr_data_i  [31:0]  full-word write data
//   mem_wr_sig_i           write strobe, sampled at the responder's clock edge
//   mem_rd_data_o  [31:0]  combinational read data for the current mem_addr_i
//
// Modports:
//   master  - CPU side: drives address, write data and strobe, receives read data
//   slave   - responder side: the reverse
// ---------------------------------------------------------------------------------------------
`timescale 1ns / 1ps

interface dmem_responder_if;

    logic [31:0] mem_addr_i;
    logic [31:0] mem_wr_data_i;
    logic        mem_wr_sig_i;
    logic [31:0] mem_rd_data_o;

    modport master (
        output mem_addr_i,
        output mem_wr_data_i,
        output mem_wr_sig_i,
        input  mem_rd_data_o
    );

    modport slave (
        input  mem_addr_i,
        input  mem_wr_data_i,
        input  mem_wr_sig_i,
        output mem_rd_data_o
    );

endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder for the CPU MEM stage: a word-addressed data RAM plus a 32-byte MMIO
// window holding GPIO, an optional timer and a status register. Reads are combinational so the
// CPU can capture them into MEM/WB at the next edge; writes commit at the clock edge.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   bus           dmem_responder_if.slave (address, write data, write strobe, read data)
//   gpio_in_i     asynchronous external inputs, double-flop synchronised before use
//   gpio_out_o    GPIO output register
//   timer_irq_o   registered timer interrupt (match flag gated by irq_en)
//   bad_addr_o    sticky flag, set by a write to an unmapped address
//
// Build option:
//   DMEM_TIMER_EN  when defined, the timer (TIMER_CNT/TIMER_CMP/TIMER_CTRL, STATUS.bit0 and
//                  timer_irq_o) is built. When undefined those registers read 0, ignore writes,
//                  and timer_irq_o is tied low.
//
// MMIO map (byte offset from MMIO_BASE):
//   0x00 GPIO_OUT   RW   0x04 GPIO_IN    RO   0x08 TIMER_CNT  RW   0x0C TIMER_CMP RW
//   0x10 STATUS     W1C  0x14 TIMER_CTRL RW   0x18/0x1C reserved (read 0, writes ignored)
// ---------------------------------------------------------------------------------------------
`timescale 1ns / 1ps

module dmem_responder #(
    parameter int unsigned RAM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
    parameter int unsigned GPIO_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus,
    input  logic [GPIO_W-1:0] gpio_in_i,
    output logic [GPIO_W-1:0] gpio_out_o,
    output logic              timer_irq_o,
    output logic              bad_addr_o
);

    localparam int unsigned RamAw    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    // 33 bits so a RAM filling the whole 4 GiB space still compares correctly.
    localparam logic [32:0] RamBytes = 33'(RAM_WORDS) * 33'd4;

    // MMIO word offsets (byte offset >> 2).
    localparam logic [2:0] OffGpioOut   = 3'd0;
    localparam logic [2:0] OffGpioIn    = 3'd1;
    localparam logic [2:0] OffTimerCnt  = 3'd2;
    localparam logic [2:0] OffTimerCmp  = 3'd3;
    localparam logic [2:0] OffStatus    = 3'd4;
    localparam logic [2:0] OffTimerCtrl = 3'd5;

    // -----------------------------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------------------------
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic             wr;
    logic             ram_hit;
    logic             mmio_hit;
    logic [31:0]      mmio_off;
    logic [2:0]       mmio_idx;
    logic [RamAw-1:0] ram_idx;
    logic             ram_we;
    logic             mmio_we;
    logic             bad_we;
    logic             status_we;

    assign addr  = bus.mem_addr_i;
    assign wdata = bus.mem_wr_data_i;
    assign wr    = bus.mem_wr_sig_i;

    // Bounds are word aligned, so comparing the full address is the same as ignoring bits [1:0].
    assign ram_hit  = ({1'b0, addr} < RamBytes);
    // Subtract-and-compare keeps the decode correct even for a non-32-byte-aligned base.
    assign mmio_off = addr - MMIO_BASE;
    assign mmio_hit = !ram_hit && (mmio_off < 32'h20);
    assign mmio_idx = mmio_off[4:2];
    assign ram_idx  = addr[RamAw+1:2];

    assign ram_we    = wr && ram_hit;
    assign mmio_we   = wr && mmio_hit;
    assign bad_we    = wr && !ram_hit && !mmio_hit;
    assign status_we = mmio_we && (mmio_idx == OffStatus);

    // -----------------------------------------------------------------------------------------
    // Data RAM: asynchronous read, synchronous write, never cleared.
    // -----------------------------------------------------------------------------------------
    logic [31:0] ram_mem [RAM_WORDS];

    // A write coinciding with an asserted reset is dropped.
    always_ff @(posedge clk) begin
        if (ram_we && !reset) begin
            ram_mem[ram_idx] <= wdata;
        end
    end

    // -----------------------------------------------------------------------------------------
    // GPIO and bad-address flag
    // -----------------------------------------------------------------------------------------
    logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
    logic [GPIO_W-1:0] gpio_sync1_q;
    logic [GPIO_W-1:0] gpio_sync2_q;
    logic              bad_q, bad_d;

    always_comb begin
        gpio_out_d = gpio_out_q;
        bad_d      = bad_q;
        if (mmio_we && (mmio_idx == OffGpioOut)) begin
            gpio_out_d = wdata[GPIO_W-1:0];
        end
        if (status_we && wdata[1]) begin
            bad_d = 1'b0;
        end
        // Only writes are flagged: the CPU drives speculative addresses on non-memory ops.
        if (bad_we) begin
            bad_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_out_q   <= '0;
            gpio_sync1_q <= '0;
            gpio_sync2_q <= '0;
            bad_q        <= 1'b0;
        end else begin
            gpio_out_q   <= gpio_out_d;
            gpio_sync1_q <= gpio_in_i;
            gpio_sync2_q <= gpio_sync1_q;
            bad_q        <= bad_d;
        end
    end

    assign gpio_out_o = gpio_out_q;
    assign bad_addr_o = bad_q;

    // -----------------------------------------------------------------------------------------
    // Timer
    // -----------------------------------------------------------------------------------------
    logic match_q;

`ifdef DMEM_TIMER_EN
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] cmp_q, cmp_d;
    logic [2:0]  ctrl_q, ctrl_d;     // {irq_en, auto_reload, en}
    logic        match_d;
    logic        irq_q, irq_d;
    logic        timer_match;

    assign timer_match = ctrl_q[0] && (cnt_q == cmp_q);

    always_comb begin
        cnt_d   = cnt_q;
        cmp_d   = cmp_q;
        ctrl_d  = ctrl_q;
        match_d = match_q;
        if (ctrl_q[0]) begin
            cnt_d = (timer_match && ctrl_q[1]) ? 32'd0 : cnt_q + 32'd1;
        end
        // A CPU write to the counter overrides both increment and auto-reload.
        if (mmio_we && (mmio_idx == OffTimerCnt)) begin
            cnt_d = wdata;
        end
        if (mmio_we && (mmio_idx == OffTimerCmp)) begin
            cmp_d = wdata;
        end
        if (mmio_we && (mmio_idx == OffTimerCtrl)) begin
            ctrl_d = wdata[2:0];
        end
        if (status_we && wdata[0]) begin
            match_d = 1'b0;
        end
        // Set after clear so a coincident match wins over W1C.
        if (timer_match) begin
            match_d = 1'b1;
        end
        irq_d = match_q && ctrl_q[2];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            cmp_q   <= '0;
            ctrl_q  <= '0;
            match_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            cmp_q   <= cmp_d;
            ctrl_q  <= ctrl_d;
            match_q <= match_d;
            irq_q   <= irq_d;
        end
    end

    assign timer_irq_o = irq_q;
`else
    assign match_q     = 1'b0;
    assign timer_irq_o = 1'b0;
`endif

    // -----------------------------------------------------------------------------------------
    // Read mux: pure function of address and current state (old RAM data during a write).
    // -----------------------------------------------------------------------------------------
    logic [31:0] gpio_out_rd;
    logic [31:0] gpio_in_rd;
    logic [31:0] rd_data;

    always_comb begin
        gpio_out_rd               = '0;
        gpio_in_rd                = '0;
        gpio_out_rd[GPIO_W-1:0]   = gpio_out_q;
        gpio_in_rd[GPIO_W-1:0]    = gpio_sync2_q;
    end

    always_comb begin
        rd_data = 32'h0;
        if (ram_hit) begin
            rd_data = ram_mem[ram_idx];
        end else if (mmio_hit) begin
            case (mmio_idx)
                OffGpioOut:   rd_data = gpio_out_rd;
                OffGpioIn:    rd_data = gpio_in_rd;
                OffStatus:    rd_data = {30'h0, bad_q, match_q};
`ifdef DMEM_TIMER_EN
                OffTimerCnt:  rd_data = cnt_q;
                OffTimerCmp:  rd_data = cmp_q;
                OffTimerCtrl: rd_data = {29'h0, ctrl_q};
`endif
                default:      rd_data = 32'h0;
            endcase
        end
    end

    assign bus.mem_rd_data_o = rd_data;

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns / 1ps

module tb_dmem_responder;

    localparam logic [31:0] MB = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;
    logic        timer_irq;
    logic        bad_addr;

    int n_run  = 0;
    int n_fail = 0;

    dmem_responder_if bus ();

    dmem_responder #(
        .RAM_WORDS (1024),
        .MMIO_BASE (32'h1000_0000),
        .GPIO_W    (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .gpio_in_i   (gpio_in),
        .gpio_out_o  (gpio_out),
        .timer_irq_o (timer_irq),
        .bad_addr_o  (bad_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000ns");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs then change and outputs are sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.mem_addr_i    = a;
        bus.mem_wr_data_i = d;
        bus.mem_wr_sig_i  = 1'b1;
        tick();
        bus.mem_wr_sig_i  = 1'b0;
    endtask

    task automatic check_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.mem_addr_i = a;
        #1;
        check(tag, bus.mem_rd_data_o, exp);
    endtask

    initial begin
        logic [31:0] v;
        bit          found;

        reset             = 1'b1;
        gpio_in           = 16'h0;
        bus.mem_addr_i    = 32'h0;
        bus.mem_wr_data_i = 32'h0;
        bus.mem_wr_sig_i  = 1'b0;
        #12;
        check("rst_gpio_out", 32'(gpio_out), 32'h0);
        check("rst_irq", 32'(timer_irq), 32'h0);
        check("rst_bad", 32'(bad_addr), 32'h0);
        reset = 1'b0;
        tick();

        // RAM write, same-cycle old data, next-cycle new data, top word and boundary.
        wr(32'h0, 32'h1111_0000);
        wr(32'h40, 32'h1111_1111);
        bus.mem_addr_i    = 32'h40;
        bus.mem_wr_data_i = 32'hDEAD_BEEF;
        bus.mem_wr_sig_i  = 1'b1;
        #1;
        check("ram_same_cycle_old", bus.mem_rd_data_o, 32'h1111_1111);
        tick();
        bus.mem_wr_sig_i = 1'b0;
        check_rd("ram_next_cycle_new", 32'h40, 32'hDEAD_BEEF);
        wr(32'hFFC, 32'h5A5A_0FFC);
        check_rd("ram_last_word", 32'hFFC, 32'h5A5A_0FFC);
        check_rd("ram_past_end_zero", 32'h1000, 32'h0);

        // GPIO out and synchronised GPIO in.
        wr(MB, 32'h0001_A5A5);
        check("gpio_out_pin", 32'(gpio_out), 32'h0000_A5A5);
        check_rd("gpio_out_read", MB, 32'h0000_A5A5);
        gpio_in = 16'h1234;
        tick();
        check_rd("gpio_in_1cyc_old", MB + 32'h4, 32'h0);
        tick();
        check_rd("gpio_in_2cyc_new", MB + 32'h4, 32'h0000_1234);

        // Reserved MMIO words.
        wr(MB + 32'h18, 32'hFFFF_FFFF);
        check("reserved_wr_noflag", 32'(bad_addr), 32'h0);
        check_rd("reserved_18_zero", MB + 32'h18, 32'h0);
        check_rd("reserved_1c_zero", MB + 32'h1C, 32'h0);

        // Unmapped write: flagged, dropped (0x2000_0000 would alias RAM word 0 if undecoded).
        wr(32'h2000_0000, 32'hCAFE_F00D);
        check("unmapped_wr_flag", 32'(bad_addr), 32'h1);
        check_rd("unmapped_wr_ram_intact", 32'h0, 32'h1111_0000);
        check_rd("unmapped_wr_gpio_intact", MB, 32'h0000_A5A5);
        check_rd("status_bad_bit", MB + 32'h10, 32'h2);
        check_rd("unmapped_rd_zero", 32'h2000_0000, 32'h0);
        wr(MB + 32'h10, 32'h2);
        check("bad_w1c_clear", 32'(bad_addr), 32'h0);
        bus.mem_addr_i = 32'h2000_0000;
        tick();
        tick();
        check("unmapped_rd_noflag", 32'(bad_addr), 32'h0);

`ifdef DMEM_TIMER_EN
        // Auto-reload match.
        wr(MB + 32'hC, 32'd5);
        wr(MB + 32'h8, 32'd0);
        wr(MB + 32'h14, 32'h7);
        check_rd("ctrl_read", MB + 32'h14, 32'h7);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.mem_addr_i = MB + 32'h8;
            #1;
            v = bus.mem_rd_data_o;
            if (v == 32'd5) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("cnt_reaches_cmp", 32'(found), 32'h1);
        check_rd("status_pre_match", MB + 32'h10, 32'h0);
        tick();
        check_rd("match_flag_set", MB + 32'h10, 32'h1);
        check_rd("cnt_auto_reload", MB + 32'h8, 32'h0);
        check("irq_not_yet", 32'(timer_irq), 32'h0);
        tick();
        check("irq_rises", 32'(timer_irq), 32'h1);
        wr(MB + 32'h10, 32'h1);
        check_rd("match_w1c_clear", MB + 32'h10, 32'h0);
        check("irq_held_one_cycle", 32'(timer_irq), 32'h1);
        tick();
        check("irq_drops", 32'(timer_irq), 32'h0);

        // Counter write beats increment.
        wr(MB + 32'h8, 32'h100);
        check_rd("cnt_write_priority", MB + 32'h8, 32'h100);

        // Match set coincident with W1C: set wins.
        wr(MB + 32'h14, 32'h0);
        check_rd("status_clear_before", MB + 32'h10, 32'h0);
        wr(MB + 32'h8, 32'h20);
        wr(MB + 32'hC, 32'h20);
        wr(MB + 32'h14, 32'h1);
        wr(MB + 32'h10, 32'h1);
        check_rd("match_set_wins", MB + 32'h10, 32'h1);
        check_rd("cnt_no_reload", MB + 32'h8, 32'h21);

        // Arm irq and counter for the reset test.
        wr(MB + 32'h14, 32'h5);
        wr(MB + 32'h8, 32'h50);
        check("irq_before_reset", 32'(timer_irq), 32'h1);
`else
        wr(MB + 32'h8, 32'h1234);
        wr(MB + 32'hC, 32'h5);
        wr(MB + 32'h14, 32'h7);
        check_rd("notimer_cnt_zero", MB + 32'h8, 32'h0);
        check_rd("notimer_cmp_zero", MB + 32'hC, 32'h0);
        tick();
        check_rd("notimer_ctrl_zero", MB + 32'h14, 32'h0);
        check_rd("notimer_status_zero", MB + 32'h10, 32'h0);
        check("notimer_irq_zero", 32'(timer_irq), 32'h0);
`endif

        // Asynchronous reset pulse between edges.
        wr(32'h3000_0000, 32'h0);
        check("bad_before_reset", 32'(bad_addr), 32'h1);
        reset = 1'b1;
        #1;
        check("async_rst_gpio_out", 32'(gpio_out), 32'h0);
        check("async_rst_bad", 32'(bad_addr), 32'h0);
        check("async_rst_irq", 32'(timer_irq), 32'h0);
        #1;
        reset = 1'b0;
        tick();
        check_rd("post_rst_gpio_reg", MB, 32'h0);
        check_rd("post_rst_status", MB + 32'h10, 32'h0);
        check_rd("ram_survives_reset", 32'h40, 32'hDEAD_BEEF);
`ifdef DMEM_TIMER_EN
        tick();
        check_rd("post_rst_cnt", MB + 32'h8, 32'h0);
        check_rd("post_rst_ctrl", MB + 32'h14, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
